median_filter_3x3: RTL and testbench

//  Downstream consumer of the 3x3 sliding-window stage: takes one 9-pixel window per valid cycle,

---
 rtl/median_filter_3x3.sv | 158 +++++++++++++++
 tb/tb_median_filter_3x3.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/median_filter_3x3.sv
// 3x3 median filter: three-stage column-sort / reduce / median-of-three pipeline.
// Frame-border windows and bypass mode pass the centre pixel through unchanged.
module median_filter_3x3 #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned IMAGE_WIDTH  = 1920,
  parameter int unsigned IMAGE_HEIGHT = 1080
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [8:0][DATA_WIDTH-1:0] in_data,
  input  logic [7:0]                 in_user,
  input  logic                       in_valid,
  output logic                       out_ready,
  input  logic                       in_enable,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [7:0]                 out_user,
  output logic                       out_valid,
  input  logic                       in_ready
);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  localparam int unsigned XW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [XW-1:0] XLast = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(IMAGE_HEIGHT - 1);

  function automatic pix_t max2(pix_t a, pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min2(pix_t a, pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t med3(pix_t a, pix_t b, pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // No stall capability: downstream ready is deliberately unused.
  logic unused_in_ready;
  assign unused_in_ready = in_ready;
  assign out_ready       = 1'b1;

  // Position of the centre pixel of the incoming window.
  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;
  logic          border;

  always_comb begin
    cur_x  = (in_user == 8'd1) ? '0 : x_q;
    cur_y  = (in_user == 8'd1) ? '0 : y_q;
    border = (cur_x == '0) || (cur_x == XLast) || (cur_y == '0) || (cur_y == YLast);
    x_d    = x_q;
    y_d    = y_q;
    if (in_valid) begin
      if (cur_x == XLast) begin
        x_d = '0;
        y_d = (cur_y == YLast) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end
  end

  // Stage 1 combinational: sort each column into lo/mid/hi.
  logic [2:0][DATA_WIDTH-1:0] col_lo, col_mid, col_hi;

  always_comb begin
    col_lo  = '0;
    col_mid = '0;
    col_hi  = '0;
    for (int c = 0; c < 3; c++) begin
      col_lo[c]  = min2(min2(in_data[3*c], in_data[3*c+1]), in_data[3*c+2]);
      col_mid[c] = med3(in_data[3*c], in_data[3*c+1], in_data[3*c+2]);
      col_hi[c]  = max2(max2(in_data[3*c], in_data[3*c+1]), in_data[3*c+2]);
    end
  end

  logic [2:0][DATA_WIDTH-1:0] s1_lo_q, s1_mid_q, s1_hi_q;
  pix_t                       s1_centre_q;
  logic [7:0]                 s1_user_q;
  logic                       s1_border_q, s1_enable_q, s1_valid_q;

  // Stage 2 combinational: median of 9 reduces to median of these three.
  pix_t st2_a, st2_b, st2_c;

  always_comb begin
    st2_a = max2(max2(s1_lo_q[0], s1_lo_q[1]), s1_lo_q[2]);
    st2_b = med3(s1_mid_q[0], s1_mid_q[1], s1_mid_q[2]);
    st2_c = min2(min2(s1_hi_q[0], s1_hi_q[1]), s1_hi_q[2]);
  end

  pix_t       s2_a_q, s2_b_q, s2_c_q, s2_centre_q;
  logic [7:0] s2_user_q;
  logic       s2_bypass_q, s2_valid_q;

  pix_t st3_res;

  always_comb begin
    st3_res = s2_bypass_q ? s2_centre_q : med3(s2_a_q, s2_b_q, s2_c_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      s1_lo_q     <= '0;
      s1_mid_q    <= '0;
      s1_hi_q     <= '0;
      s1_centre_q <= '0;
      s1_user_q   <= '0;
      s1_border_q <= 1'b0;
      s1_enable_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_a_q      <= '0;
      s2_b_q      <= '0;
      s2_c_q      <= '0;
      s2_centre_q <= '0;
      s2_user_q   <= '0;
      s2_bypass_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_data    <= '0;
      out_user    <= '0;
      out_valid   <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      out_valid  <= s2_valid_q;
      // Data registers only load with a valid beat; bubbles leave them holding.
      if (in_valid) begin
        s1_lo_q     <= col_lo;
        s1_mid_q    <= col_mid;
        s1_hi_q     <= col_hi;
        s1_centre_q <= in_data[4];
        s1_user_q   <= in_user;
        s1_border_q <= border;
        s1_enable_q <= in_enable;
      end
      if (s1_valid_q) begin
        s2_a_q      <= st2_a;
        s2_b_q      <= st2_b;
        s2_c_q      <= st2_c;
        s2_centre_q <= s1_centre_q;
        s2_user_q   <= s1_user_q;
        s2_bypass_q <= s1_border_q | ~s1_enable_q;
      end
      if (s2_valid_q) begin
        out_data <= st3_res;
        out_user <= s2_user_q;
      end
    end
  end

endmodule

// File: tb/tb_median_filter_3x3.sv
// Self-checking bench for median_filter_3x3 on an 8x8 image: directed table, corner
// sequences and random traffic against a sort-based reference model.
module tb_median_filter_3x3;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DW = 16;

  typedef logic [8:0][DW-1:0] win_t;

  logic           clk = 1'b0;
  logic           reset;
  win_t           in_data;
  logic [7:0]     in_user;
  logic           in_valid;
  logic           out_ready;
  logic           in_enable;
  logic [DW-1:0]  out_data;
  logic [7:0]     out_user;
  logic           out_valid;
  logic           in_ready;

  always #5 clk = ~clk;

  median_filter_3x3 #(
    .DATA_WIDTH  (DW),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_user  (in_user),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_enable(in_enable),
    .out_data (out_data),
    .out_user (out_user),
    .out_valid(out_valid),
    .in_ready (in_ready)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
    logic [7:0]    user;
  } exp_t;

  typedef struct packed {
    logic [3:0]    x;
    logic [3:0]    y;
    logic [7:0]    user;
    logic          en;
    logic [DW-1:0] exp;
    logic [7:0]    exp_user;
    win_t          win;
  } vec_t;

  exp_t pend[$];
  vec_t tv[$];
  int   mx, my;  // model position of the next accepted window

  logic          obs_valid;
  logic [DW-1:0] obs_data;
  logic [7:0]    obs_user;

  function automatic int med9(win_t w);
    int a[9];
    int t;
    for (int i = 0; i < 9; i++) a[i] = int'(w[i]);
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  function automatic win_t rand_win(int maxv);
    win_t w;
    for (int i = 0; i < 9; i++) w[i] = DW'($urandom_range(maxv, 0));
    return w;
  endfunction

  function automatic vec_t mk(int x, int y, int u, int en, int ex, int eu,
                              int w0, int w1, int w2, int w3, int w4,
                              int w5, int w6, int w7, int w8);
    vec_t v;
    v.x = 4'(x); v.y = 4'(y); v.user = 8'(u); v.en = 1'(en);
    v.exp = DW'(ex); v.exp_user = 8'(eu);
    v.win[0] = DW'(w0); v.win[1] = DW'(w1); v.win[2] = DW'(w2);
    v.win[3] = DW'(w3); v.win[4] = DW'(w4); v.win[5] = DW'(w5);
    v.win[6] = DW'(w6); v.win[7] = DW'(w7); v.win[8] = DW'(w8);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle, predict its result, and compare the output due from two calls earlier.
  task automatic cycle(input logic v, input win_t w, input logic [7:0] u, input logic en);
    exp_t e;
    exp_t o;
    logic brd;
    in_valid  = v;
    in_data   = w;
    in_user   = u;
    in_enable = en;
    e = '0;
    if (v) begin
      if (u == 8'd1) begin mx = 0; my = 0; end
      brd = (mx == 0) || (mx == W - 1) || (my == 0) || (my == H - 1);
      e.valid = 1'b1;
      e.user  = u;
      e.data  = (brd || !en) ? w[4] : DW'(med9(w));
      mx = mx + 1;
      if (mx == W) begin
        mx = 0;
        my = (my + 1) % H;
      end
    end
    pend.push_back(e);
    @(posedge clk);
    #1;
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_user  = out_user;
    o = pend.pop_front();
    check("out_valid", int'(out_valid), int'(o.valid));
    if (o.valid) begin
      check("out_data", int'(out_data), int'(o.data));
      check("out_user", int'(out_user), int'(o.user));
    end
  endtask

  task automatic idle();
    cycle(1'b0, '0, 8'd0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    pend.delete();
    pend.push_back('0);
    pend.push_back('0);
    mx = 0;
    my = 0;
  endtask

  task automatic goto_pos(input int x, input int y);
    while (mx != x || my != y) cycle(1'b1, rand_win(65535), 8'd0, 1'b1);
  endtask

  initial begin
    logic [4:0] vpat;
    int         seen;
    vec_t       t;
    win_t       noisy;

    reset     = 1'b1;
    in_data   = '0;
    in_user   = '0;
    in_valid  = 1'b0;
    in_enable = 1'b1;
    in_ready  = 1'b1;
    mx = 0;
    my = 0;

    do_reset(2);
    check("reset_valid", int'(out_valid), 0);
    check("reset_data", int'(out_data), 0);
    check("reset_user", int'(out_user), 0);
    check("out_ready", int'(out_ready), 1);

    tv.push_back(mk(3, 3, 0, 1, 5, 0, 9, 1, 8, 2, 5, 7, 3, 6, 4));
    tv.push_back(mk(4, 2, 0, 1, 100, 0, 100, 100, 4095, 100, 100, 100, 100, 100, 100));
    tv.push_back(mk(5, 5, 0, 1, 7, 0, 7, 7, 7, 7, 7, 7, 7, 7, 7));
    tv.push_back(mk(0, 0, 1, 1, 42, 1, 1000, 0, 65535, 3, 42, 9, 500, 7, 2));
    tv.push_back(mk(7, 3, 0, 1, 42, 0, 1000, 0, 65535, 3, 42, 9, 500, 7, 2));
    tv.push_back(mk(3, 0, 0, 1, 42, 0, 1000, 0, 65535, 3, 42, 9, 500, 7, 2));
    tv.push_back(mk(3, 7, 0, 1, 42, 0, 1000, 0, 65535, 3, 42, 9, 500, 7, 2));
    tv.push_back(mk(2, 4, 0, 1, 9, 0, 1000, 0, 65535, 3, 42, 9, 500, 7, 2));
    tv.push_back(mk(3, 3, 0, 0, 50, 0, 0, 0, 0, 0, 50, 0, 0, 0, 0));
    tv.push_back(mk(3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 50, 0, 0, 0, 0));

    foreach (tv[i]) begin
      t = tv[i];
      if (t.user != 8'd1) goto_pos(int'(t.x), int'(t.y));
      cycle(1'b1, t.win, t.user, t.en);
      idle();
      idle();
      check("tbl_valid", int'(obs_valid), 1);
      check("tbl_data", int'(obs_data), int'(t.exp));
      check("tbl_user", int'(obs_user), int'(t.exp_user));
    end

    // in_valid 1,0,1,1,0 must re-appear on out_valid two calls later.
    vpat = '0;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0, 2, 3: cycle(1'b1, rand_win(255), 8'd0, 1'b1);
        default: idle();
      endcase
      if (i >= 2) vpat = {vpat[3:0], obs_valid};
    end
    check("valid_pattern", int'(vpat), int'(5'b10110));

    // Reset with two windows in flight: nothing emerges, position restarts at (0,0).
    goto_pos(3, 3);
    cycle(1'b1, rand_win(65535), 8'd0, 1'b1);
    cycle(1'b1, rand_win(65535), 8'd0, 1'b1);
    do_reset(1);
    seen = 0;
    repeat (4) begin
      idle();
      seen += int'(obs_valid);
    end
    check("flush", seen, 0);
    noisy = tv[3].win;
    cycle(1'b1, noisy, 8'd0, 1'b1);
    idle();
    idle();
    check("reset_resync", int'(obs_data), 42);

    // Random traffic, occasional frame starts and resets.
    repeat (600) begin
      logic [7:0] u;
      u = 8'($urandom_range(255, 0));
      if (u == 8'd1) u = 8'd2;
      if ($urandom_range(39, 0) == 0) u = 8'd1;
      if ($urandom_range(199, 0) == 0) do_reset(1);
      cycle($urandom_range(9, 0) < 7,
            rand_win(($urandom_range(1, 0) == 0) ? 7 : 65535),
            u, $urandom_range(4, 0) != 0);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
